// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - IF/data arbiter onto one async SRAM; RAM_WAIT_STATE_EN stretches READ/WRITE to 2 cycles
module ram_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WREC} state_t;

  state_t            state_q, state_d;
  logic              cur_mem_q, cur_mem_d;    // requester owning the current access (1 = mem)
  logic              last_mem_q, last_mem_d;  // requester granted most recently (1 = mem)
  logic              grant_mem;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              if_ack_d, mem_ack_d;
  logic              rd_done;
  logic              phase_done;              // current READ/WRITE phase ends this cycle

`ifdef RAM_WAIT_STATE_EN
  logic wait_q, wait_d;

  // Wait-state flag: low in the first cycle of READ/WRITE, high in the second
  always_comb begin
    wait_d     = ((state_q == READ) || (state_q == WRITE)) && !wait_q;
    phase_done = wait_q;
  end

  // Wait-state register
  always_ff @(posedge clk) begin
    if (!rst) wait_q <= 1'b0;
    else      wait_q <= wait_d;
  end
`else
  // Without wait states every READ/WRITE phase lasts a single cycle
  always_comb begin
    phase_done = 1'b1;
  end
`endif

  // Pipeline hold: a requester waits until its own ack pulse
  assign stall = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  // Next-state, arbitration and ack generation
  always_comb begin
    state_d    = state_q;
    cur_mem_d  = cur_mem_q;
    last_mem_d = last_mem_q;
    addr_d     = ram_addr;
    wdata_d    = ram_wdata;
    if_ack_d   = 1'b0;
    mem_ack_d  = 1'b0;
    rd_done    = 1'b0;
    grant_mem  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          // On contention the requester not served last wins
          grant_mem  = mem_req & (~if_req | ~last_mem_q);
          cur_mem_d  = grant_mem;
          last_mem_d = grant_mem;
          addr_d     = grant_mem ? mem_addr : if_addr;
          if (grant_mem) wdata_d = mem_wdata;
          state_d    = (grant_mem && mem_we) ? WRITE : READ;
        end
      end
      READ: begin
        if (phase_done) begin
          state_d   = IDLE;
          rd_done   = 1'b1;
          if_ack_d  = ~cur_mem_q;
          mem_ack_d = cur_mem_q;
        end
      end
      WRITE: begin
        if (phase_done) state_d = WREC;
      end
      WREC: begin
        state_d   = IDLE;
        mem_ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered SRAM strobes (strobes follow the next state)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_mem_q    <= 1'b0;
      last_mem_q   <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      ram_wdata_oe <= 1'b0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      if_ack       <= 1'b0;
      mem_ack      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_mem_q    <= cur_mem_d;
      last_mem_q   <= last_mem_d;
      ram_addr     <= addr_d;
      ram_wdata    <= wdata_d;
      ram_ce_n     <= (state_d == IDLE);
      ram_oe_n     <= (state_d != READ);
      ram_we_n     <= (state_d != WRITE);
      ram_wdata_oe <= (state_d == WRITE) || (state_d == WREC);
      if_ack       <= if_ack_d;
      mem_ack      <= mem_ack_d;
      if (rd_done) begin
        if (cur_mem_q) mem_rdata <= ram_rdata;
        else           if_rdata  <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;
`ifdef RAM_WAIT_STATE_EN
  localparam int RL = 2;
  localparam int WL = 2;
`else
  localparam int RL = 1;
  localparam int WL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [15:0] if_addr, mem_addr, mem_wdata;
  logic [15:0] if_rdata, mem_rdata;
  logic        if_ack, mem_ack, stall;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_wdata_oe, ram_ce_n, ram_oe_n, ram_we_n;

  logic [15:0] sram [0:255];
  logic        pl_en, fill_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          preload;
    logic [15:0] pdata;
    logic [15:0] exp_rdata;
  } vec_t;

  // transaction-level reference model state
  bit          m_busy, m_mem, m_we, m_last_mem, m_access;
  int          m_age, m_n;
  logic [15:0] m_addr, m_wdata, e_ram_addr, e_if_rdata, e_mem_rdata;
  bit          e_if_ack, e_mem_ack;
  logic [15:0] mm [0:255];

  ram_access_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
    .ram_rdata(ram_rdata), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fill_val(input int i);
    return 16'((i * 775) ^ 42435);
  endfunction

  // SRAM device model
  assign ram_rdata = sram[ram_addr[7:0]];
  always @(posedge clk) begin
    if (fill_en) for (int i = 0; i < 256; i++) sram[8'(i)] <= fill_val(i);
    else if (pl_en) sram[pl_addr] <= pl_data;
    else if (!ram_ce_n && !ram_we_n) sram[ram_addr[7:0]] <= ram_wdata;
  end

  task automatic chkb(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One isolated transaction: latency, strobe shape, stall and returned data
  task automatic run_vec(input vec_t v);
    int  n, lat, oe_cnt, we_cnt, rec_cnt;
    bit  got;
    logic ack;
    if (v.preload) begin
      pl_en = 1'b1; pl_addr = v.addr[7:0]; pl_data = v.pdata;
      tick();
      pl_en = 1'b0;
    end
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1 chkb("stall_on_req", stall, 1'b1);
    got = 0; lat = 0; oe_cnt = 0; we_cnt = 0; rec_cnt = 0; n = 0;
    while (!got && n < 12) begin
      tick();
      n++;
      if (!ram_oe_n) oe_cnt++;
      if (!ram_we_n) we_cnt++;
      if (!ram_ce_n && ram_we_n && ram_wdata_oe) rec_cnt++;
      if (!ram_ce_n) begin
        chkw("vec_ram_addr", ram_addr, v.addr);
        if (ram_wdata_oe) chkw("vec_ram_wdata", ram_wdata, v.wdata);
      end
      ack = v.is_mem ? mem_ack : if_ack;
      if (ack) begin
        got = 1; lat = n;
      end else begin
        chkb("stall_until_ack", stall, 1'b1);
      end
    end
    chkb("vec_ack_seen", got, 1'b1);
    chki("vec_ack_latency", lat, (v.is_mem && v.we) ? WL + 2 : RL + 1);
    chki("vec_oe_low_cycles", oe_cnt, v.we ? 0 : RL);
    chki("vec_we_low_cycles", we_cnt, v.we ? WL : 0);
    chki("vec_wrec_cycles", rec_cnt, v.we ? 1 : 0);
    chkb("vec_other_ack", v.is_mem ? if_ack : mem_ack, 1'b0);
    chkb("vec_stall_in_ack", stall, 1'b0);
    if (v.is_mem) chkw("vec_mem_rdata", mem_rdata, v.exp_rdata);
    else          chkw("vec_if_rdata", if_rdata, v.exp_rdata);
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    chkb("vec_ack_one_cycle", if_ack | mem_ack, 1'b0);
  endtask

  // Advance the reference model across one clock edge using the inputs present at that edge
  task automatic model_step();
    if (!m_busy || m_age >= m_n + 1) begin
      m_busy = 0;
      if (if_req || mem_req) begin
        if (if_req && mem_req) m_mem = !m_last_mem;
        else                   m_mem = mem_req;
        m_last_mem = m_mem;
        m_we       = m_mem && mem_we;
        m_addr     = m_mem ? mem_addr : if_addr;
        m_wdata    = mem_wdata;
        m_n        = m_we ? WL + 1 : RL;
        m_age      = 1;
        m_busy     = 1;
        e_ram_addr = m_addr;
      end
    end else begin
      m_age++;
    end
    e_if_ack  = m_busy && (m_age == m_n + 1) && !m_mem;
    e_mem_ack = m_busy && (m_age == m_n + 1) && m_mem;
    if (m_busy && m_age == m_n + 1) begin
      if (m_we)       mm[m_addr[7:0]] = m_wdata;
      else if (m_mem) e_mem_rdata = mm[m_addr[7:0]];
      else            e_if_rdata  = mm[m_addr[7:0]];
    end
    m_access = m_busy && (m_age <= m_n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   seen, ackc;
    int   lat, k;

    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    pl_en = 1'b0; fill_en = 1'b0; pl_addr = '0; pl_data = '0;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 16'h0101, 16'h0101};
    vecs[3] = '{1'b1, 1'b1, 16'h0020, 16'h5555, 1'b0, 16'h0000, 16'h0101};
    vecs[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'hA5A5, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h5555};
    vecs[6] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h0000, 16'hBEEF};

    // reset values
    tick(); tick();
    chkb("rst_ce_n", ram_ce_n, 1'b1);
    chkb("rst_oe_n", ram_oe_n, 1'b1);
    chkb("rst_we_n", ram_we_n, 1'b1);
    chkb("rst_wdata_oe", ram_wdata_oe, 1'b0);
    chkw("rst_ram_addr", ram_addr, 16'h0000);
    chkw("rst_ram_wdata", ram_wdata, 16'h0000);
    chkw("rst_if_rdata", if_rdata, 16'h0000);
    chkw("rst_mem_rdata", mem_rdata, 16'h0000);
    chkb("rst_if_ack", if_ack, 1'b0);
    chkb("rst_mem_ack", mem_ack, 1'b0);
    chkb("rst_stall", stall, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // both requesters held from reset: mem, IF, mem, IF with no extra idle cycle
    if_req = 1'b1; if_addr = 16'h0030;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0040;
    do_reset();
    for (int c = 1; c <= 4 * (RL + 1); c++) begin
      tick();
      ackc = (c % (RL + 1)) == 0;
      k    = c / (RL + 1);
      chkb("alt_mem_ack", mem_ack, ackc && (k % 2 == 1));
      chkb("alt_if_ack", if_ack, ackc && (k % 2 == 0));
      chkb("alt_ce_n", ram_ce_n, ackc);
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick(); tick();

    // reset during WRITE aborts the access
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0077; mem_wdata = 16'hDEAD;
    tick();
    chkb("abort_we_started", ram_we_n, 1'b0);
    rst = 1'b0;
    tick();
    chkb("abort_we_n", ram_we_n, 1'b1);
    chkb("abort_ce_n", ram_ce_n, 1'b1);
    chkb("abort_wdata_oe", ram_wdata_oe, 1'b0);
    chkb("abort_mem_ack", mem_ack, 1'b0);
    rst = 1'b1; mem_req = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      seen = seen | mem_ack;
    end
    chkb("abort_no_ack_later", seen, 1'b0);
    v = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h1234};
    run_vec(v);

    // request dropped mid-access still completes and acks
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
    tick();
    mem_req = 1'b0;
    seen = 0; lat = 0;
    for (int c = 2; c <= RL + 3; c++) begin
      tick();
      if (mem_ack && !seen) begin
        seen = 1; lat = c;
      end
    end
    chkb("drop_ack_seen", seen, 1'b1);
    chki("drop_ack_latency", lat, RL + 1);
    chkw("drop_mem_rdata", mem_rdata, 16'h1234);

    // randomized traffic against the reference model
    if_req = 1'b0; mem_req = 1'b0;
    do_reset();
    fill_en = 1'b1;
    tick();
    fill_en = 1'b0;
    for (int i = 0; i < 256; i++) mm[8'(i)] = fill_val(i);
    m_busy = 0; m_last_mem = 0; m_age = 0; m_n = 0; m_mem = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; e_ram_addr = '0; e_if_rdata = '0; e_mem_rdata = '0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      tick();
      model_step();
      chkb("rnd_ce_n", ram_ce_n, !m_access);
      chkb("rnd_oe_n", ram_oe_n, !(m_access && !m_we));
      chkb("rnd_we_n", ram_we_n, !(m_access && m_we && m_age <= WL));
      chkb("rnd_wdata_oe", ram_wdata_oe, m_access && m_we);
      chkw("rnd_ram_addr", ram_addr, e_ram_addr);
      if (m_access && m_we) chkw("rnd_ram_wdata", ram_wdata, m_wdata);
      chkb("rnd_if_ack", if_ack, e_if_ack);
      chkb("rnd_mem_ack", mem_ack, e_mem_ack);
      chkw("rnd_if_rdata", if_rdata, e_if_rdata);
      chkw("rnd_mem_rdata", mem_rdata, e_mem_rdata);
      chkb("rnd_we_oe_overlap", !ram_we_n && !ram_oe_n, 1'b0);
      chkb("rnd_drive_while_oe", ram_wdata_oe && !ram_oe_n, 1'b0);
      if (if_req) begin
        if (e_if_ack) begin
          if ($urandom_range(0, 1) == 1) if_addr = 16'($urandom_range(0, 15));
          else if_req = 1'b0;
        end
      end else if ($urandom_range(0, 9) < 3) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 15));
      end
      if (mem_req) begin
        if (e_mem_ack) begin
          if ($urandom_range(0, 1) == 1) begin
            mem_addr = 16'($urandom_range(0, 15));
            mem_we = 1'($urandom_range(0, 1)); mem_wdata = 16'($urandom);
          end else mem_req = 1'b0;
        end
      end else if ($urandom_range(0, 9) < 3) begin
        mem_req = 1'b1; mem_addr = 16'($urandom_range(0, 15));
        mem_we = 1'($urandom_range(0, 1)); mem_wdata = 16'($urandom);
      end
      #1;
      chkb("rnd_stall", stall, (if_req && !e_if_ack) || (mem_req && !e_mem_ack));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
